booth_pp_reduce_acc: RTL and testbench

// - Downstream stage of the radix-4 Booth partial-product generator inside the weight-stationary PE.
// - Reduces the four 10-bit Booth partial products of an 8x8 signed multiply to a 16-bit product.
// - Adds that product either to the partial sum arriving from the PE above (chain mode)
//   or to a local accumulator (local mode).
// - Registered 2-stage pipeline with valid tracking and a global stall.

---
 rtl/booth_pkg.sv | 19 +
 rtl/booth_pp_reduce_acc_if.sv | 28 ++
 rtl/booth_pp_compress.sv | 33 +++
 rtl/booth_pp_reduce_acc.sv | 77 +++++++
 tb/tb_booth_pp_reduce_acc.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth partial-product reduction path.
package booth_pkg;

  localparam int unsigned PP_W     = 10;
  localparam int unsigned PROD_W   = 16;
  localparam int unsigned NUM_PP   = 4;
  localparam int unsigned PP_SHIFT = 2;

  typedef logic signed [PP_W-1:0]   pp_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  // Sign-extend a partial product to product width and place it at weight 4^idx.
  function automatic prod_t pp_align(input pp_t pp, input int unsigned idx);
    prod_t w_ext;
    w_ext = prod_t'(pp);
    return w_ext <<< (PP_SHIFT * idx);
  endfunction

endpackage

// File: rtl/booth_pp_reduce_acc_if.sv
// Beat interface between the Booth PP generator and the reduce/accumulate stage.
interface booth_pp_reduce_acc_if #(
  parameter int unsigned ACC_W = 32
);
  import booth_pkg::*;

  logic             valid_i;
  pp_t              pp1_i;
  pp_t              pp2_i;
  pp_t              pp3_i;
  pp_t              pp4_i;
  logic             mode_i;
  logic             acc_clr_i;
  logic [ACC_W-1:0] psum_i;
  logic             valid_o;
  logic [ACC_W-1:0] psum_o;

  modport master (
    output valid_i, pp1_i, pp2_i, pp3_i, pp4_i, mode_i, acc_clr_i, psum_i,
    input  valid_o, psum_o
  );

  modport slave (
    input  valid_i, pp1_i, pp2_i, pp3_i, pp4_i, mode_i, acc_clr_i, psum_i,
    output valid_o, psum_o
  );

endinterface

// File: rtl/booth_pp_compress.sv
// Combinational 4:2 carry-save compressor plus final adder: four Booth PPs -> 16-bit product.
module booth_pp_compress
  import booth_pkg::*;
(
  input  pp_t   i_pp1,
  input  pp_t   i_pp2,
  input  pp_t   i_pp3,
  input  pp_t   i_pp4,
  output prod_t o_prod_c
);

  logic [PROD_W-1:0] w_x [NUM_PP];
  logic [PROD_W-1:0] w_s1;
  logic [PROD_W-1:0] w_c1;
  logic [PROD_W-1:0] w_s2;
  logic [PROD_W-1:0] w_c2;

  assign w_x[0] = pp_align(i_pp1, 0);
  assign w_x[1] = pp_align(i_pp2, 1);
  assign w_x[2] = pp_align(i_pp3, 2);
  assign w_x[3] = pp_align(i_pp4, 3);

  // Two 3:2 layers form the 4:2 compressor; carries dropped past bit 15 are exact mod 2^16.
  always_comb begin
    w_s1 = w_x[0] ^ w_x[1] ^ w_x[2];
    w_c1 = ((w_x[0] & w_x[1]) | (w_x[0] & w_x[2]) | (w_x[1] & w_x[2])) << 1;
    w_s2 = w_s1 ^ w_c1 ^ w_x[3];
    w_c2 = ((w_s1 & w_c1) | (w_s1 & w_x[3]) | (w_c1 & w_x[3])) << 1;
  end

  assign o_prod_c = prod_t'(w_s2 + w_c2);

endmodule

// File: rtl/booth_pp_reduce_acc.sv
// Two-stage pipeline: reduce Booth PPs to a product, then add to chain psum or local accumulator.
module booth_pp_reduce_acc
  import booth_pkg::*;
#(
  parameter int unsigned ACC_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  booth_pp_reduce_acc_if.slave  bus
);

  prod_t            w_prod;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [ACC_W-1:0] w_psum_nxt;
  logic             w_valid_nxt;

  logic             r_s1_valid;
  prod_t            r_s1_prod;
  logic             r_s1_mode;
  logic             r_s1_clr;
  logic             r_valid_o;
  logic [ACC_W-1:0] r_psum;
  logic [ACC_W-1:0] r_acc;

  booth_pp_compress u_compress (
    .i_pp1    (bus.pp1_i),
    .i_pp2    (bus.pp2_i),
    .i_pp3    (bus.pp3_i),
    .i_pp4    (bus.pp4_i),
    .o_prod_c (w_prod)
  );

  assign w_prod_ext = ACC_W'(r_s1_prod);

  // Stage-2 next state: chain add or accumulator update; holds when no beat is present.
  always_comb begin
    w_acc_nxt   = r_acc;
    w_psum_nxt  = r_psum;
    w_valid_nxt = 1'b0;
    if (r_s1_valid) begin
      w_valid_nxt = 1'b1;
      if (r_s1_mode) begin
        w_acc_nxt  = r_s1_clr ? w_prod_ext : r_acc + w_prod_ext;
        w_psum_nxt = w_acc_nxt;
      end else begin
        w_psum_nxt = bus.psum_i + w_prod_ext;
      end
    end
  end

  // Pipeline registers; a stall freezes every one of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_prod  <= '0;
      r_s1_mode  <= 1'b0;
      r_s1_clr   <= 1'b0;
      r_valid_o  <= 1'b0;
      r_psum     <= '0;
      r_acc      <= '0;
    end else if (!stall_i) begin
      r_s1_valid <= bus.valid_i;
      r_s1_prod  <= w_prod;
      r_s1_mode  <= bus.mode_i;
      r_s1_clr   <= bus.acc_clr_i;
      r_valid_o  <= w_valid_nxt;
      r_psum     <= w_psum_nxt;
      r_acc      <= w_acc_nxt;
    end
  end

  assign bus.valid_o = r_valid_o;
  assign bus.psum_o  = r_psum;

endmodule

// File: tb/tb_booth_pp_reduce_acc.sv
// Scoreboard bench: 32-bit and 16-bit accumulator instances driven with identical beats.
module tb_booth_pp_reduce_acc;
  import booth_pkg::*;

  typedef struct {
    logic        v;
    int          a;
    int          b;
    logic        mode;
    logic        clr;
    logic [31:0] psum;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic stall;

  always #5 clk = ~clk;

  booth_pp_reduce_acc_if #(.ACC_W(32)) bus32 ();
  booth_pp_reduce_acc_if #(.ACC_W(16)) bus16 ();

  booth_pp_reduce_acc #(.ACC_W(32)) dut32 (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall),
    .bus     (bus32)
  );

  booth_pp_reduce_acc #(.ACC_W(16)) dut16 (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall),
    .bus     (bus16)
  );

  int total = 0;
  int bad   = 0;

  beat_t       s1;
  logic [31:0] acc32;
  logic [15:0] acc16;
  logic [31:0] q32 [$];
  logic [15:0] q16 [$];
  logic        exp_v = 1'b0;
  logic        exp_v_nxt = 1'b0;
  logic        edge_stalled = 1'b0;
  logic [31:0] last32 = '0;
  logic [15:0] last16 = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h) t=%0t",
               tag, $signed(got), got, $signed(exp), exp, $time);
    end
  endtask

  // Radix-4 Booth recoding of b, each digit times a, packed as four 10-bit PPs.
  function automatic logic [39:0] booth(input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  bx;
    logic [39:0] r;
    int          d;
    int          av;
    bx = {b, 1'b0};
    av = int'($signed(a));
    r  = '0;
    for (int i = 0; i < 4; i++) begin
      d = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
      r[10*i +: 10] = 10'(d * av);
    end
    return r;
  endfunction

  task automatic drive_pps(input logic [39:0] pw);
    bus32.pp1_i = pp_t'(pw[9:0]);
    bus32.pp2_i = pp_t'(pw[19:10]);
    bus32.pp3_i = pp_t'(pw[29:20]);
    bus32.pp4_i = pp_t'(pw[39:30]);
    bus16.pp1_i = pp_t'(pw[9:0]);
    bus16.pp2_i = pp_t'(pw[19:10]);
    bus16.pp3_i = pp_t'(pw[29:20]);
    bus16.pp4_i = pp_t'(pw[39:30]);
  endtask

  task automatic drive_ctl(input logic v, input logic mode, input logic clr);
    bus32.valid_i   = v;
    bus32.mode_i    = mode;
    bus32.acc_clr_i = clr;
    bus16.valid_i   = v;
    bus16.mode_i    = mode;
    bus16.acc_clr_i = clr;
  endtask

  // One clock of stimulus; psum is the partial sum belonging to this beat (presented next cycle).
  task automatic cycle(input logic st, input logic v, input int a, input int b,
                       input logic mode, input logic clr, input logic [31:0] psum);
    int p;
    logic [31:0] junk;
    @(negedge clk);
    stall = st;
    if (st) begin
      junk = $urandom;
      drive_pps({$urandom, junk[7:0]});
      drive_ctl(1'($urandom), 1'($urandom), 1'($urandom));
      bus32.psum_i = $urandom;
      bus16.psum_i = 16'($urandom);
      exp_v_nxt = exp_v;
      return;
    end
    bus32.psum_i = s1.psum;
    bus16.psum_i = s1.psum[15:0];
    if (s1.v) begin
      p = s1.a * s1.b;
      if (s1.mode) begin
        acc32 = s1.clr ? 32'(p) : acc32 + 32'(p);
        acc16 = s1.clr ? 16'(p) : acc16 + 16'(p);
        q32.push_back(acc32);
        q16.push_back(acc16);
      end else begin
        q32.push_back(s1.psum + 32'(p));
        q16.push_back(s1.psum[15:0] + 16'(p));
      end
    end
    exp_v_nxt = s1.v;
    s1 = '{v: v, a: a, b: b, mode: mode, clr: clr, psum: psum};
    drive_pps(booth(8'(a), 8'(b)));
    drive_ctl(v, mode, clr);
  endtask

  task automatic beat(input int a, input int b, input logic mode, input logic clr,
                      input logic [31:0] psum);
    cycle(1'b0, 1'b1, a, b, mode, clr, psum);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_valid32", 32'(bus32.valid_o), 32'd0);
    check("rst_psum32", bus32.psum_o, 32'd0);
    check("rst_valid16", 32'(bus16.valid_o), 32'd0);
    check("rst_psum16", 32'(bus16.psum_o), 32'd0);
    s1        = '{v: 1'b0, a: 0, b: 0, mode: 1'b0, clr: 1'b0, psum: 32'd0};
    acc32     = '0;
    acc16     = '0;
    exp_v_nxt = 1'b0;
    q32.delete();
    q16.delete();
    drive_ctl(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    edge_stalled <= stall;
    exp_v        <= exp_v_nxt;
  end

  // Output monitor: valid timing, frozen outputs under stall, in-order result check.
  always @(negedge clk) begin
    if (!rst) begin
      check("valid32", 32'(bus32.valid_o), 32'(exp_v));
      check("valid16", 32'(bus16.valid_o), 32'(exp_v));
      if (edge_stalled) begin
        check("hold32", bus32.psum_o, last32);
        check("hold16", 32'(bus16.psum_o), 32'(last16));
      end else begin
        if (bus32.valid_o) begin
          check("pending32", 32'(q32.size() != 0), 32'd1);
          if (q32.size() != 0) check("psum32", bus32.psum_o, q32.pop_front());
        end
        if (bus16.valid_o) begin
          check("pending16", 32'(q16.size() != 0), 32'd1);
          if (q16.size() != 0) check("psum16", 32'(bus16.psum_o), 32'(q16.pop_front()));
        end
      end
      last32 = bus32.psum_o;
      last16 = bus16.psum_o;
    end
  end

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    s1    = '{v: 1'b0, a: 0, b: 0, mode: 1'b0, clr: 1'b0, psum: 32'd0};
    acc32 = '0;
    acc16 = '0;
    drive_pps('0);
    drive_ctl(1'b0, 1'b0, 1'b0);
    bus32.psum_i = '0;
    bus16.psum_i = '0;
    #1;
    check("init_valid32", 32'(bus32.valid_o), 32'd0);
    check("init_psum32", bus32.psum_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // chain: 7 * -3 + 100
    beat(7, -3, 1'b0, 1'b0, 32'd100);
    idle(3);

    // corner products, chain with zero psum, back to back
    beat(-128, -128, 1'b0, 1'b0, 32'd0);
    beat(-128, 127, 1'b0, 1'b0, 32'd0);
    beat(0, -1, 1'b0, 1'b0, 32'd0);
    idle(3);

    // local accumulate sequence
    beat(2, 3, 1'b1, 1'b1, 32'd0);
    beat(-4, 5, 1'b1, 1'b0, 32'd0);
    beat(10, 10, 1'b1, 1'b0, 32'd0);
    idle(2);

    // chain beat with clr set must not disturb the accumulator
    beat(3, 3, 1'b0, 1'b1, 32'd5);
    beat(1, 1, 1'b1, 1'b0, 32'd0);
    idle(3);

    // stall with two beats in flight
    beat(5, 6, 1'b0, 1'b0, 32'd1000);
    beat(-7, 8, 1'b0, 1'b0, 32'd2000);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 32'd0);
    idle(3);

    // wrap at 16 bits (32-bit instance sees 32768)
    beat(1, 1, 1'b0, 1'b0, 32'd32767);
    beat(-128, -128, 1'b1, 1'b1, 32'd0);
    beat(-128, -128, 1'b1, 1'b0, 32'd0);
    idle(3);

    // reset with a valid beat in stage 1, then stale accumulator check
    beat(9, 9, 1'b1, 1'b0, 32'd0);
    do_reset();
    beat(1, 1, 1'b1, 1'b0, 32'd0);
    idle(3);

    // random traffic with random stalls
    for (int i = 0; i < 400; i++) begin
      cycle(1'b0 == ($urandom_range(4) != 0) ? 1'b1 : 1'b0,
            1'($urandom), int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
            1'($urandom), ($urandom_range(5) == 0) ? 1'b1 : 1'b0, $urandom);
    end
    idle(4);

    check("drain32", 32'(q32.size()), 32'd0);
    check("drain16", 32'(q16.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
